// File: rtl/ppd_pkg.sv
// Shared helpers for the polyphase decimation (PPD) filter: ceiling division,
// phase-counter width and the phase-to-slot mapping used by the commutator
// and the downstream multiply-add stage.
package ppd_pkg;

    // Ceiling of num/den for positive operands.
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Phase counter width: max(1, $clog2(d)), so d=1 still has a 1-bit counter.
    function automatic int cnt_width(input int d);
        return (d <= 2) ? 1 : $clog2(d);
    endfunction

    // Physical slot for a frame phase: counter-clockwise fills from slot 0,
    // clockwise fills from slot d-1 downwards.
    function automatic int slot_idx(input int phase, input int d, input int ccw);
        return (ccw != 0) ? phase : (d - 1 - phase);
    endfunction

endpackage

// File: rtl/ppd_phase_cnt.sv
// Modulo-D phase counter for the PPD commutator. Advances on i_ena, clears on
// i_rst, and i_load restarts a frame (the current sample becomes phase 0, so
// the counter moves to 1, or wraps at once when D=1). o_wrap is combinational
// and flags the cycle on which the last phase of a frame is consumed.
module ppd_phase_cnt
    import ppd_pkg::*;
#(
    parameter int gp_modulus = 31
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_ena,
    input  logic                               i_load,
    output logic [cnt_width(gp_modulus)-1:0]   o_phase,
    output logic                               o_wrap
);

    localparam int CW = cnt_width(gp_modulus);
    // Wrap compares against D-1 explicitly; D need not be a power of two.
    localparam logic [CW-1:0] LAST = CW'(gp_modulus - 1);

    logic [CW-1:0] phase_q;
    logic [CW-1:0] phase_d;
    logic          wrap;

    // Next phase and wrap flag for the current cycle.
    always_comb begin
        phase_d = phase_q;
        wrap    = 1'b0;
        if (i_ena) begin
            if (i_load) begin
                if (gp_modulus == 1) begin
                    phase_d = '0;
                    wrap    = 1'b1;
                end else begin
                    phase_d = CW'(1);
                end
            end else if (phase_q == LAST) begin
                phase_d = '0;
                wrap    = 1'b1;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
    end

    // Phase register with synchronous clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign o_phase = phase_q;
    assign o_wrap  = wrap;

endmodule

// File: rtl/ppd_commutator.sv
// Input commutator for the PPD filter: packs D consecutive serial samples into
// one parallel frame and presents it with a one-cycle strobe at the decimated
// rate. Optional frame alignment input i_sync exists when PPD_COMM_SYNC_EN is
// defined; without it the phase counter free-runs from reset.
//
// Handshake: i_ena qualifies i_data (no back-pressure, a sample is taken on
// every cycle with i_ena=1); o_ena is a single-cycle strobe that marks a new
// o_data, which then holds until the next strobe or reset.
module ppd_commutator
    import ppd_pkg::*;
#(
    parameter int gp_idata_width       = 6,
    parameter int gp_decimation_factor = 31,
    parameter int gp_ccw               = 1
) (
    input  logic                                             i_clk,
    input  logic                                             i_rst,
    input  logic                                             i_ena,
`ifdef PPD_COMM_SYNC_EN
    input  logic                                             i_sync,
`endif
    input  logic signed [gp_idata_width-1:0]                 i_data,
    output logic [gp_decimation_factor*gp_idata_width-1:0]   o_data,
    output logic                                             o_ena,
    output logic [cnt_width(gp_decimation_factor)-1:0]       o_phase
);

    localparam int W  = gp_idata_width;
    localparam int D  = gp_decimation_factor;
    localparam int CW = cnt_width(D);

    logic [CW-1:0]  phase;
    logic [CW-1:0]  phase_eff;
    logic [CW-1:0]  slot_sel;
    logic           wrap;
    logic           sync_hit;
    logic [D*W-1:0] fill_q;
    logic [D*W-1:0] fill_next;

`ifdef PPD_COMM_SYNC_EN
    assign sync_hit = i_ena & i_sync;
`else
    assign sync_hit = 1'b0;
`endif

    ppd_phase_cnt #(
        .gp_modulus (D)
    ) u_phase_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_ena   (i_ena),
        .i_load  (sync_hit),
        .o_phase (phase),
        .o_wrap  (wrap)
    );

    // A sync sample always opens a new frame, so it takes phase 0's slot.
    assign phase_eff = sync_hit ? '0 : phase;
    assign slot_sel  = CW'(slot_idx(int'(phase_eff), D, gp_ccw));

    // Fill register with the current sample merged in; the output register
    // loads this so the final sample of a frame is included without delay.
    for (genvar s = 0; s < D; s++) begin : g_slot
        assign fill_next[s*W +: W] = (i_ena && (slot_sel == CW'(s)))
                                     ? i_data : fill_q[s*W +: W];
    end

    // Fill register: slots are overwritten in place, never cleared on wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fill_q <= '0;
        end else if (i_ena) begin
            fill_q <= fill_next;
        end
    end

    // Output frame and strobe, updated only when a frame completes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data <= '0;
            o_ena  <= 1'b0;
        end else begin
            o_ena <= wrap;
            if (wrap) begin
                o_data <= fill_next;
            end
        end
    end

    assign o_phase = phase;

endmodule

// File: tb/tb_ppd_commutator.sv
// Directed bench for ppd_commutator: table-driven vectors on a D=4 ccw
// instance, plus hand-written sequences for clockwise order, D=3, D=1 and
// (when PPD_COMM_SYNC_EN is defined) frame alignment.
module tb_ppd_commutator;

    logic       i_clk;
    logic       i_rst;
    logic       i_ena;
    logic [5:0] i_data;
`ifdef PPD_COMM_SYNC_EN
    logic       i_sync;
`endif

    logic [23:0] d4_data;
    logic        d4_ena;
    logic [1:0]  d4_phase;
    logic [23:0] cw_data;
    logic        cw_ena;
    logic [1:0]  cw_phase;
    logic [17:0] d3_data;
    logic        d3_ena;
    logic [1:0]  d3_phase;
    logic [5:0]  d1_data;
    logic        d1_ena;
    logic [0:0]  d1_phase;

    int n_vec = 0;
    int n_err = 0;

    // clock / reset
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    ppd_commutator #(.gp_idata_width(6), .gp_decimation_factor(4), .gp_ccw(1)) dut_d4 (
        .i_clk(i_clk), .i_rst(i_rst), .i_ena(i_ena),
`ifdef PPD_COMM_SYNC_EN
        .i_sync(i_sync),
`endif
        .i_data(i_data), .o_data(d4_data), .o_ena(d4_ena), .o_phase(d4_phase));

    ppd_commutator #(.gp_idata_width(6), .gp_decimation_factor(4), .gp_ccw(0)) dut_cw (
        .i_clk(i_clk), .i_rst(i_rst), .i_ena(i_ena),
`ifdef PPD_COMM_SYNC_EN
        .i_sync(i_sync),
`endif
        .i_data(i_data), .o_data(cw_data), .o_ena(cw_ena), .o_phase(cw_phase));

    ppd_commutator #(.gp_idata_width(6), .gp_decimation_factor(3), .gp_ccw(1)) dut_d3 (
        .i_clk(i_clk), .i_rst(i_rst), .i_ena(i_ena),
`ifdef PPD_COMM_SYNC_EN
        .i_sync(i_sync),
`endif
        .i_data(i_data), .o_data(d3_data), .o_ena(d3_ena), .o_phase(d3_phase));

    ppd_commutator #(.gp_idata_width(6), .gp_decimation_factor(1), .gp_ccw(1)) dut_d1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_ena(i_ena),
`ifdef PPD_COMM_SYNC_EN
        .i_sync(i_sync),
`endif
        .i_data(i_data), .o_data(d1_data), .o_ena(d1_ena), .o_phase(d1_phase));

    typedef struct {
        logic        rst;
        logic        ena;
        logic [5:0]  data;
        logic        exp_ena;
        logic [23:0] exp_data;
        logic [1:0]  exp_phase;
    } vec_t;

    vec_t tv[$];

    // Frame of four samples, slot 0 in the LSBs.
    function automatic logic [23:0] f4(input logic [5:0] s0, input logic [5:0] s1,
                                       input logic [5:0] s2, input logic [5:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    task automatic add_vec(input logic rst, input logic ena, input logic [5:0] data,
                           input logic exp_ena, input logic [23:0] exp_data,
                           input logic [1:0] exp_phase);
        vec_t v;
        v.rst = rst; v.ena = ena; v.data = data;
        v.exp_ena = exp_ena; v.exp_data = exp_data; v.exp_phase = exp_phase;
        tv.push_back(v);
    endtask

    // driver: apply one cycle of inputs, return 1 time unit after the edge
    task automatic step(input logic rst, input logic ena, input logic [5:0] data,
                        input logic sync);
        i_rst  = rst;
        i_ena  = ena;
        i_data = data;
`ifdef PPD_COMM_SYNC_EN
        i_sync = sync;
`else
        if (sync) $display("note: sync request ignored in this build");
`endif
        @(posedge i_clk);
        #1;
    endtask

    // scoreboard compare
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [23:0] fa;
        logic [23:0] fb;
        i_rst  = 1'b1;
        i_ena  = 1'b0;
        i_data = '0;
`ifdef PPD_COMM_SYNC_EN
        i_sync = 1'b0;
`endif

        // ---- vector table for the D=4 counter-clockwise instance ----
        add_vec(1, 0, 6'h00, 0, 24'h0, 2'd0);                 // reset
        fa = f4(6'd1, 6'd2, 6'd3, 6'd4);
        fb = f4(6'd5, 6'd6, 6'd7, 6'd8);
        for (int k = 1; k <= 8; k++) begin                   // back-to-back 1..8
            add_vec(0, 1, 6'(k), (k % 4) == 0,
                    (k < 4) ? 24'h0 : ((k < 8) ? fa : fb), 2'(k % 4));
        end
        // gapped enable: 1,0,0,1,1,0,1 with -32,x,x,31,-1,x,7
        add_vec(0, 1, 6'h20, 0, fb, 2'd1);
        add_vec(0, 0, 6'h15, 0, fb, 2'd1);
        add_vec(0, 0, 6'h2A, 0, fb, 2'd1);
        add_vec(0, 1, 6'h1F, 0, fb, 2'd2);
        add_vec(0, 1, 6'h3F, 0, fb, 2'd3);
        add_vec(0, 0, 6'h11, 0, fb, 2'd3);
        fa = f4(6'h20, 6'h1F, 6'h3F, 6'h07);
        add_vec(0, 1, 6'h07, 1, fa, 2'd0);
        add_vec(0, 0, 6'h00, 0, fa, 2'd0);                   // hold after strobe
        // two samples, reset mid-frame, then 10..13
        add_vec(0, 1, 6'd20, 0, fa, 2'd1);
        add_vec(0, 1, 6'd21, 0, fa, 2'd2);
        add_vec(1, 1, 6'd22, 0, 24'h0, 2'd0);
        add_vec(0, 1, 6'd10, 0, 24'h0, 2'd1);
        add_vec(0, 1, 6'd11, 0, 24'h0, 2'd2);
        add_vec(0, 1, 6'd12, 0, 24'h0, 2'd3);
        add_vec(0, 1, 6'd13, 1, f4(6'd10, 6'd11, 6'd12, 6'd13), 2'd0);
        add_vec(0, 0, 6'd00, 0, f4(6'd10, 6'd11, 6'd12, 6'd13), 2'd0);

        foreach (tv[i]) begin
            step(tv[i].rst, tv[i].ena, tv[i].data, 1'b0);
            chk($sformatf("tv%0d_ena", i),   64'(d4_ena),   64'(tv[i].exp_ena));
            chk($sformatf("tv%0d_data", i),  64'(d4_data),  64'(tv[i].exp_data));
            chk($sformatf("tv%0d_phase", i), 64'(d4_phase), 64'(tv[i].exp_phase));
        end

        // ---- clockwise D=4, D=3 and D=1 on a continuous 1..8 stream ----
        step(1, 0, 6'h00, 1'b0);
        chk("rst_cw_data", 64'(cw_data), 64'h0);
        chk("rst_d1_data", 64'(d1_data), 64'h0);
        chk("rst_d3_phase", 64'(d3_phase), 64'h0);
        for (int k = 1; k <= 8; k++) begin
            step(0, 1, 6'(k), 1'b0);
            chk($sformatf("cw_ena_%0d", k), 64'(cw_ena), 64'((k % 4) == 0));
            chk($sformatf("cw_phase_%0d", k), 64'(cw_phase), 64'(k % 4));
            if (k == 4) chk("cw_frame1", 64'(cw_data), 64'(f4(6'd4, 6'd3, 6'd2, 6'd1)));
            if (k == 8) chk("cw_frame2", 64'(cw_data), 64'(f4(6'd8, 6'd7, 6'd6, 6'd5)));
            chk($sformatf("d3_ena_%0d", k), 64'(d3_ena), 64'((k % 3) == 0));
            chk($sformatf("d3_phase_%0d", k), 64'(d3_phase), 64'(k % 3));
            if (k == 3) chk("d3_frame1", 64'(d3_data), 64'({6'd3, 6'd2, 6'd1}));
            if (k == 6) chk("d3_frame2", 64'(d3_data), 64'({6'd6, 6'd5, 6'd4}));
            chk($sformatf("d1_ena_%0d", k), 64'(d1_ena), 64'h1);
            chk($sformatf("d1_data_%0d", k), 64'(d1_data), 64'(k));
            chk($sformatf("d1_phase_%0d", k), 64'(d1_phase), 64'h0);
        end

        // ---- D=1: samples 3, -4 then idle ----
        step(0, 1, 6'd3, 1'b0);
        chk("d1_s3_ena", 64'(d1_ena), 64'h1);
        chk("d1_s3_data", 64'(d1_data), 64'h03);
        step(0, 1, 6'h3C, 1'b0);
        chk("d1_m4_ena", 64'(d1_ena), 64'h1);
        chk("d1_m4_data", 64'(d1_data), 64'h3C);
        step(0, 0, 6'h00, 1'b0);
        chk("d1_idle_ena", 64'(d1_ena), 64'h0);
        chk("d1_idle_data", 64'(d1_data), 64'h3C);

`ifdef PPD_COMM_SYNC_EN
        // ---- sync realigns the frame: 1,2 then 9(sync),8,7,6 ----
        step(1, 0, 6'h00, 1'b0);
        step(0, 1, 6'd1, 1'b0);
        chk("sync_pre1_ena", 64'(d4_ena), 64'h0);
        step(0, 1, 6'd2, 1'b0);
        chk("sync_pre2_ena", 64'(d4_ena), 64'h0);
        step(0, 1, 6'd9, 1'b1);
        chk("sync_ena", 64'(d4_ena), 64'h0);
        chk("sync_phase", 64'(d4_phase), 64'h1);
        step(0, 1, 6'd8, 1'b0);
        chk("sync_8_ena", 64'(d4_ena), 64'h0);
        step(0, 1, 6'd7, 1'b0);
        chk("sync_7_ena", 64'(d4_ena), 64'h0);
        step(0, 1, 6'd6, 1'b0);
        chk("sync_frame_ena", 64'(d4_ena), 64'h1);
        chk("sync_frame", 64'(d4_data), 64'(f4(6'd9, 6'd8, 6'd7, 6'd6)));
        step(0, 0, 6'h00, 1'b1);
        chk("sync_idle_ena", 64'(d4_ena), 64'h0);
        chk("sync_idle_phase", 64'(d4_phase), 64'h0);
`endif

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ppd_commutator.md
Name: ppd_commutator

Overview:
- Input commutator for the polyphase decimation (PPD) filter.
- Accepts one signed serial sample per enabled clock at the high input rate.
- Packs gp_decimation_factor consecutive samples into one parallel vector, then emits the vector with a one-cycle output strobe at the decimated rate.
- Output vector and strobe drive the data and enable inputs of the PPD multiply-add stage directly downstream.

Parameters:
- gp_idata_width, 6: signed sample width in bits.
- gp_decimation_factor, 31: samples per frame (D), i.e. number of polyphase branches; legal range 1..1024.
- gp_ccw, 1: slot order. 1 = counter-clockwise, first sample of a frame lands in slot 0 (LSBs). 0 = clockwise, first sample lands in slot D-1 (MSBs).

Ports:
- i_clk  in  1  rising-edge clock.
- i_rst  in  1  synchronous active-high reset.
- i_ena  in  1  input sample qualifier; a sample is accepted only on a cycle with i_ena=1.
- i_data  in  gp_idata_width  signed serial input sample.
- o_data  out  gp_decimation_factor*gp_idata_width  packed frame; slot s occupies bits [(s+1)*W-1 -: W].
- o_ena  out  1  one-cycle strobe marking a new o_data; drives the downstream stage enable.
- o_phase  out  max(1,$clog2(D))  index of the next slot to be filled (0..D-1).

Behaviour:
- Reset: i_rst is sampled on i_clk; one clock with i_rst=1 clears all state.
  - o_data=0, o_ena=0, o_phase=0.
  - Internal fill register is cleared to 0.
- Reset mid-frame: any partial frame is discarded. The next accepted sample is slot 0, and no o_ena is produced for the aborted frame.
- Accept: on a cycle with i_ena=1, the sample is written to the fill register at slot phase (gp_ccw=1) or slot D-1-phase (gp_ccw=0). Phase then increments.
- Wrap: when phase==D-1 and a sample is accepted, on the next rising edge:
  - phase returns to 0;
  - o_data loads the complete frame, including the sample just accepted;
  - o_ena=1 for exactly that one cycle.
- Latency: o_data/o_ena are registered and valid one clock after the D-th sample is accepted.
- Hold: o_data keeps its value between strobes; it changes only on a strobe or on reset.
- Idle: when i_ena=0, phase and the fill register hold, and o_ena=0 on the following cycle.
- Back-to-back: with i_ena held at 1, o_ena pulses every D cycles, with no bubbles and no sample lost across the wrap.
- Fill register: after a wrap it is not cleared. Slots are overwritten as the new frame arrives; o_data is isolated from it.
- D=1: every accepted sample produces o_ena on the next cycle, and o_phase is constant 0.
- Arithmetic: none. Samples are passed bit-exact with no sign extension or truncation.
- Phase counter: width max(1,$clog2(D)); the wrap compare is against D-1, not a power of two.

Optional Feature:
- Macro: PPD_COMM_SYNC_EN
- Defined: adds input port i_sync (1 bit).
  - i_sync=1 together with i_ena=1 forces the current sample into slot 0 and sets phase to 1 (or wraps immediately if D=1).
  - Any partial frame is discarded, with no o_ena for it.
  - Used to align the frame to an external decimation phase.
  - i_sync with i_ena=0 is ignored.
- Not defined: port is absent and the phase counter free-runs from reset.

Decomposition:
- Shared ppd package holds:
  - the ceiling-division helper;
  - the counter-width function max(1,$clog2(D));
  - the slot-index function (phase, D, ccw) -> slot, which the multiply-add stage also uses.
- Sub-module ppd_phase_cnt: modulo-D counter with enable, synchronous clear and optional load-to-1 (sync). It outputs phase and a wrap flag. The top level holds the fill register, output register and strobe.

Test Plan:
- D=4, W=6, ccw=1, i_ena=1 continuously, input 1,2,3,4,5,6,7,8:
  - o_ena high on the cycles after samples 4 and 8;
  - first o_data slots [0..3] = 1,2,3,4; second = 5,6,7,8.
- Same stimulus with ccw=0: first o_data slots [0..3] = 4,3,2,1.
- D=4, i_ena pattern 1,0,0,1,1,0,1 with samples -32,x,x,31,-1,x,7: o_data = {-32,31,-1,7} in slots 0..3, o_ena a single pulse, no strobe while idle.
- D=4, accept 2 samples, assert i_rst for 1 cycle, then feed 10,11,12,13:
  - o_data=0 and o_phase=0 after reset;
  - next frame = 10,11,12,13, with exactly one o_ena.
- D=1: samples 3,-4 give o_ena on 2 consecutive cycles, with o_data 3 then -4.
- PPD_COMM_SYNC_EN, D=4: feed 1,2, then 9 with i_sync=1, then 8,7,6 → frame = 9,8,7,6; no strobe for the 1,2 fragment.
